// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, free-running tick divider,
// 3-sample majority voting per bit and a one-entry valid/ack output register.
module uart_rx_param #(
   parameter int CLK_DIV     = 217,
   parameter int OVS         = 24,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 ack,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CDIV = (CLK_DIV >= 2) ? CLK_DIV : 217;
   localparam int OVSE = (OVS >= 8 && (OVS % 2) == 0) ? OVS : 24;
   localparam int DB   = (DATA_BITS >= 5 && DATA_BITS <= 9) ? DATA_BITS : 8;
   localparam int PM   = (PARITY_MODE >= 0 && PARITY_MODE <= 2) ? PARITY_MODE : 0;
   localparam int SB   = (STOP_BITS == 2) ? 2 : 1;
   localparam int SW   = (DATA_BITS > 9) ? DATA_BITS : 9;
   localparam int DW   = $clog2(CDIV);
   localparam int CW   = $clog2(OVSE);

   localparam logic [DW-1:0] DIV_LAST = DW'(CDIV - 1);
   localparam logic [CW-1:0] C_LAST   = CW'(OVSE - 1);
   localparam logic [CW-1:0] C_S0     = CW'(OVSE / 2 - 1);
   localparam logic [CW-1:0] C_S1     = CW'(OVSE / 2);
   localparam logic [CW-1:0] C_S2     = CW'(OVSE / 2 + 1);
   localparam logic [3:0]    BIT_LAST = 4'(DB - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state_q, state_d;
   logic                   rx_meta_q, rx_s_q;
   logic [DW-1:0]          div_q;
   logic                   tick;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [3:0]             bit_q, bit_d;
   logic                   stop_q, stop_d;
   logic                   s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic [SW-1:0]          sh_q, sh_d, sh_ins;
   logic                   par_q, par_d, pe_q, pe_d, fe_q, fe_d;
   logic                   hi_seen_q, hi_seen_d;
   logic [DATA_BITS-1:0]   data_q, data_d, payload;
   logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic                   maj_full, maj_early, done, fe_fin;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign tick      = (div_q == DIV_LAST);
   assign maj_full  = maj3(s0_q, s1_q, s2_q);
   // The final stop bit is decided on its third sample, before s2 is registered.
   assign maj_early = maj3(s0_q, s1_q, rx_s_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            IDLE:    if (!rx_s_q && hi_seen_q) state_d = START;
            START:   if (cnt_q == C_LAST) state_d = maj_full ? IDLE : DATA;
            DATA:    if (cnt_q == C_LAST && bit_q == BIT_LAST) state_d = (PM != 0) ? PARITY : STOP;
            PARITY:  if (cnt_q == C_LAST) state_d = STOP;
            STOP:    if ((SB == 1 || stop_q) && cnt_q == C_S2) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         div_q     <= '0;
         cnt_q     <= '0;
         bit_q     <= '0;
         stop_q    <= 1'b0;
         s0_q      <= 1'b1;
         s1_q      <= 1'b1;
         s2_q      <= 1'b1;
         sh_q      <= '0;
         par_q     <= 1'b0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         hi_seen_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         div_q     <= tick ? '0 : div_q + 1'b1;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         stop_q    <= stop_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         sh_q      <= sh_d;
         par_q     <= par_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         hi_seen_q <= hi_seen_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      stop_d    = stop_q;
      s0_d      = s0_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      sh_d      = sh_q;
      par_d     = par_q;
      pe_d      = pe_q;
      fe_d      = fe_q;
      hi_seen_d = hi_seen_q;
      data_d    = data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ovr_d     = ovr_q;
      done      = 1'b0;
      fe_fin    = fe_q;
      sh_ins    = sh_q >> 1;
      sh_ins[DB-1] = maj_full;
      payload   = '0;
      for (int i = 0; i < DATA_BITS; i++) begin
         if (i < DB) payload[i] = sh_q[i];
      end

      if (tick) begin
         cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
         if (cnt_q == C_S0) s0_d = rx_s_q;
         if (cnt_q == C_S1) s1_d = rx_s_q;
         if (cnt_q == C_S2) s2_d = rx_s_q;
         case (state_q)
            IDLE: begin
               cnt_d  = '0;
               bit_d  = '0;
               stop_d = 1'b0;
               sh_d   = '0;
               par_d  = 1'b0;
               pe_d   = 1'b0;
               fe_d   = 1'b0;
               if (rx_s_q) hi_seen_d = 1'b1;
            end
            DATA: begin
               if (cnt_q == C_LAST) begin
                  sh_d  = sh_ins;
                  par_d = par_q ^ maj_full;
                  bit_d = bit_q + 4'd1;
               end
            end
            PARITY: begin
               if (cnt_q == C_LAST) pe_d = ((par_q ^ maj_full) != (PM == 2));
            end
            STOP: begin
               if (SB == 2 && !stop_q) begin
                  if (cnt_q == C_LAST) begin
                     fe_d   = fe_q | ~maj_full;
                     stop_d = 1'b1;
                  end
               end else if (cnt_q == C_S2) begin
                  done   = 1'b1;
                  fe_fin = fe_q | ~maj_early;
                  // A low line at the end of a frame (break) must go high before the next start.
                  if (!maj_early) hi_seen_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // valid/ack: data is taken on any clk with valid && ack; a frame completing
      // while valid is high and ack is low is dropped and flagged as overrun.
      if (done) begin
         if (!valid_q || ack) begin
            data_d  = payload;
            perr_d  = pe_q;
            ferr_d  = fe_fin;
            valid_d = 1'b1;
            if (ack) ovr_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at 4 clk/tick, 8 ticks/bit across five
// framing variants: 8N1, 8E1, 8O1, 8N2 and 9N1.
module tb_uart_rx_param;
   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rx_v;
   logic [4:0] ack_v;
   logic [4:0] valid_w, perr_w, ferr_w, ovr_w, busy_w;
   logic [7:0] d0, d1, d2, d3;
   logic [8:0] d4;
   int         cyc;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   // Clock count since reset release; the divider phase follows it exactly.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   uart_rx_param #(.CLK_DIV(4), .OVS(8), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .rx(rx_v[0]), .ack(ack_v[0]), .data(d0), .valid(valid_w[0]),
      .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .overrun(ovr_w[0]), .busy(busy_w[0]));
   uart_rx_param #(.CLK_DIV(4), .OVS(8), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
      .clk(clk), .reset(reset), .rx(rx_v[1]), .ack(ack_v[1]), .data(d1), .valid(valid_w[1]),
      .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .overrun(ovr_w[1]), .busy(busy_w[1]));
   uart_rx_param #(.CLK_DIV(4), .OVS(8), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
      .clk(clk), .reset(reset), .rx(rx_v[2]), .ack(ack_v[2]), .data(d2), .valid(valid_w[2]),
      .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .overrun(ovr_w[2]), .busy(busy_w[2]));
   uart_rx_param #(.CLK_DIV(4), .OVS(8), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
      .clk(clk), .reset(reset), .rx(rx_v[3]), .ack(ack_v[3]), .data(d3), .valid(valid_w[3]),
      .parity_err(perr_w[3]), .frame_err(ferr_w[3]), .overrun(ovr_w[3]), .busy(busy_w[3]));
   uart_rx_param #(.CLK_DIV(4), .OVS(8), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(1)) u4 (
      .clk(clk), .reset(reset), .rx(rx_v[4]), .ack(ack_v[4]), .data(d4), .valid(valid_w[4]),
      .parity_err(perr_w[4]), .frame_err(ferr_w[4]), .overrun(ovr_w[4]), .busy(busy_w[4]));

   function automatic logic [15:0] dout(input int idx);
      case (idx)
         0:       return 16'(d0);
         1:       return 16'(d1);
         2:       return 16'(d2);
         3:       return 16'(d3);
         default: return 16'(d4);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int idx, input logic [8:0] ed, input logic ev,
                          input logic ep, input logic ef, input logic eo);
      chk($sformatf("%s.data", tag), dout(idx), 16'(ed));
      chk($sformatf("%s.valid", tag), 16'(valid_w[idx]), 16'(ev));
      chk($sformatf("%s.parity_err", tag), 16'(perr_w[idx]), 16'(ep));
      chk($sformatf("%s.frame_err", tag), 16'(ferr_w[idx]), 16'(ef));
      chk($sformatf("%s.overrun", tag), 16'(ovr_w[idx]), 16'(eo));
   endtask

   // Called at a negedge; each bit is held for 32 clocks, then the line idles high.
   task automatic send(input int idx, input logic [8:0] d, input int nd, input bit has_par,
                       input logic pbit, input logic st0, input logic st1, input int nst);
      logic [15:0] bits;
      int n;
      bits = '0;
      n = 1;
      for (int i = 0; i < nd; i++) begin
         bits[n] = d[i];
         n++;
      end
      if (has_par) begin
         bits[n] = pbit;
         n++;
      end
      bits[n] = st0;
      n++;
      if (nst == 2) begin
         bits[n] = st1;
         n++;
      end
      for (int i = 0; i < n; i++) begin
         rx_v[idx] = bits[i];
         repeat (32) @(negedge clk);
      end
      rx_v[idx] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic pulse_ack(input int idx);
      ack_v[idx] = 1'b1;
      @(negedge clk);
      ack_v[idx] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      rx_v  = '1;
      ack_v = '0;
      repeat (3) @(negedge clk);
      chk_out("reset", 0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.busy_all", 16'(busy_w), 16'h0);
      chk("reset.valid_all", 16'(valid_w), 16'h0);
      reset = 1'b0;
      repeat (16) @(negedge clk);

      send(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk_out("8n1_a5", 0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("8n1_a5.busy", 16'(busy_w[0]), 16'h0);
      pulse_ack(0);
      chk("ack.valid", 16'(valid_w[0]), 16'h0);

      send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      chk_out("stop_low", 0, 9'h03C, 1'b1, 1'b0, 1'b1, 1'b0);
      pulse_ack(0);

      rx_v[0] = 1'b0;
      repeat (8) @(negedge clk);
      chk("glitch.busy_hi", 16'(busy_w[0]), 16'h1);
      rx_v[0] = 1'b1;
      repeat (48) @(negedge clk);
      chk("glitch.busy_lo", 16'(busy_w[0]), 16'h0);
      chk("glitch.valid", 16'(valid_w[0]), 16'h0);

      send(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk_out("ovr_first", 0, 9'h011, 1'b1, 1'b0, 1'b0, 1'b0);
      send(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk_out("ovr_drop", 0, 9'h011, 1'b1, 1'b0, 1'b0, 1'b1);
      pulse_ack(0);
      chk("ovr_ack.valid", 16'(valid_w[0]), 16'h0);
      chk("ovr_ack.overrun", 16'(ovr_w[0]), 16'h0);
      send(0, 9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      send(0, 9'h044, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk_out("ovr_again", 0, 9'h033, 1'b1, 1'b0, 1'b0, 1'b1);
      // Start bit lands on a tick-aligned clock so the final stop decision is at start+314.
      do @(negedge clk); while ((cyc % 4) != 1);
      fork
         send(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
         begin
            repeat (314) @(negedge clk);
            ack_v[0] = 1'b1;
            @(negedge clk);
            ack_v[0] = 1'b0;
         end
      join
      chk_out("ack_at_done", 0, 9'h022, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_ack(0);

      send(1, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
      chk_out("even_p1", 1, 9'h003, 1'b1, 1'b1, 1'b0, 1'b0);
      pulse_ack(1);
      send(1, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
      chk_out("even_p0", 1, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0);
      send(2, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
      chk_out("odd_p1", 2, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_ack(2);
      send(2, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
      chk_out("odd_p0", 2, 9'h003, 1'b1, 1'b1, 1'b0, 1'b0);

      send(3, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2);
      chk_out("2stop_low", 3, 9'h03C, 1'b1, 1'b0, 1'b1, 1'b0);
      pulse_ack(3);
      send(3, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 2);
      chk_out("2stop_ok", 3, 9'h0C3, 1'b1, 1'b0, 1'b0, 1'b0);

      send(4, 9'h1FF, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk_out("9bit_1ff", 4, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_ack(4);
      send(4, 9'h10A, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk_out("9bit_10a", 4, 9'h10A, 1'b1, 1'b0, 1'b0, 1'b0);

      rx_v[0] = 1'b0;
      repeat (384) @(negedge clk);
      chk_out("break", 0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("break.busy_idle_low", 16'(busy_w[0]), 16'h0);
      rx_v[0] = 1'b1;
      repeat (40) @(negedge clk);
      pulse_ack(0);

      send(0, 9'h066, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      rx_v[0] = 1'b0;
      repeat (32) @(negedge clk);
      rx_v[0] = 1'b1;
      repeat (32) @(negedge clk);
      rx_v[0] = 1'b0;
      repeat (32) @(negedge clk);
      rx_v[0] = 1'b1;
      repeat (32) @(negedge clk);
      rx_v[0] = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_out("mid_reset", 0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_reset.busy", 16'(busy_w[0]), 16'h0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_reset.busy", 16'(busy_w[0]), 16'h0);
      rx_v[0] = 1'b1;
      repeat (64) @(negedge clk);
      chk("post_reset.valid", 16'(valid_w[0]), 16'h0);
      send(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk_out("after_reset_5a", 0, 9'h05A, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
